mips_dbg_ctrl: RTL and testbench
================================

Name: mips_dbg_ctrl

Overview:
- Sequencer between the host loader and the pipelined MIPS core.
- Accepts a program word stream over valid/ready and writes it into program memory.
- Releases the core in continuous or single-step mode and detects halt.
- After halt, dumps the register file and the first 32 data-memory words as a 32-bit word stream.

Parameters:
- PM_AW, 8: program-memory word-address width (depth = 2**PM_AW).
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that terminates loading and halts the core.
- DUMP_WORDS, 32: words dumped per bank (regfile, data mem).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- instr_valid  in  1  program word available.
- instr_data  in  32  program word.
- instr_ready  out  1  block accepts instr_data this cycle.
- start  in  1  1-cycle pulse: leave WAIT/DONE.
- run_mode  in  1  0 = continuous, 1 = step; sampled on start.
- step  in  1  level; each rising edge = one core cycle in step mode.
- cpu_halted  in  1  core reports HALT_WORD reached WB.
- pm_we  out  1  program-memory write strobe.
- pm_addr  out  PM_AW  program-memory write address.
- pm_wdata  out  32  program-memory write data.
- cpu_en  out  1  core clock enable, all pipeline registers.
- cpu_rst  out  1  synchronous reset to core, active-high.
- dbg_sel  out  1  0 = register file, 1 = data memory.
- dbg_addr  out  5  debug read address.
- dbg_rdata  in  32  combinational debug read data.
- tx_valid  out  1  dump word valid.
- tx_data  out  32  dump word.
- tx_ready  in  1  sink accepts dump word.
- cycle_cnt  out  32  core cycles executed (cpu_en-high cycles).
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset values: state = LOAD; load_ptr = 0; all strobes 0; cpu_rst = 1; cycle_cnt = 0; tx_data = 0; dbg_sel = 0; dbg_addr = 0.
- States: LOAD, WAIT, RUN, STEP, DUMP_RD, DUMP_TX, DONE.
- LOAD:
  - instr_ready = 1.
  - On each valid&ready: pm_we = 1 combinationally, pm_addr = load_ptr, pm_wdata = instr_data, load_ptr++.
  - Go to WAIT on the word equal to HALT_WORD, or on the write at load_ptr = 2**PM_AW-1 (full); no wrap.
- WAIT:
  - instr_ready = 0; cpu_rst = 1.
  - On start: run_mode = 0 → RUN, run_mode = 1 → STEP; cpu_rst deasserts from the next cycle.
- RUN:
  - cpu_en = 1 every cycle; cycle_cnt++ per cpu_en cycle, saturating at 32'hFFFF_FFFF.
  - cpu_halted = 1 → cpu_en = 0 from the next cycle, go to DUMP_RD.
- STEP:
  - step rising edge uses a registered previous value; it produces exactly one cpu_en cycle.
  - step held high produces no further pulses.
  - cpu_halted → DUMP_RD. If halt arrives in the same cycle as a step edge, the pulse is still issued, then DUMP_RD.
- Dump sequence (dump_ptr 0..2*DUMP_WORDS-1):
  - dbg_sel = dump_ptr[5], dbg_addr = dump_ptr[4:0].
  - DUMP_RD lasts one cycle: registers dbg_rdata into tx_data, then DUMP_TX.
  - DUMP_TX: tx_valid = 1; tx_data is held stable until tx_ready.
  - On tx_valid&tx_ready: dump_ptr++ and go to DUMP_RD, or to DONE after the last word.
  - Exactly 2*DUMP_WORDS words are transferred; back-pressure of any length is tolerated.
- DONE:
  - cpu_rst = 1; cycle_cnt is held.
  - start → LOAD, clearing load_ptr, dump_ptr and cycle_cnt.
- start outside WAIT/DONE is ignored; step outside STEP is ignored.
- RESET_N low at any time aborts immediately to reset values. Program-memory contents are untouched.

Optional Feature:
- Macro: DBG_CYCLE_DUMP_EN.
- Defined: the dump sends one extra word, cycle_cnt, after the last data-memory word (2*DUMP_WORDS+1 words total), using the same RD/TX handshake.
- Undefined: exactly 2*DUMP_WORDS words; cycle_cnt is visible only on its port.

Decomposition:
- Package mips_dbg_pkg:
  - State encoding localparams.
  - HALT_WORD default.
  - DUMP bank select constants.
- One sub-module, dbg_edge_det: registered rising-edge detector for step.
- Everything else in one module.

Test Plan:
- Load 3 words 0x2001_0005, 0x2002_0007, 0xFFFF_FFFF with continuous valid → pm_we high 3 cycles at addrs 0, 1, 2; instr_ready low from cycle 4; state_o = WAIT.
- Stall instr_valid between words for 5 cycles → no pm_we during gaps; addresses still contiguous 0..N.
- Fill without halt, 2**PM_AW words → last write at addr 255; state WAIT; instr_ready 0, no wrap to 0.
- Step mode, 4 step edges with halt after the 4th → exactly 4 cpu_en pulses; cycle_cnt = 4; step held high 10 cycles gives 1 pulse.
- Continuous run with halt on cycle 20, tx_ready toggling 1/0 → 64 tx words in order: reg0..reg31, then mem0..mem31; tx_data stable while tx_valid & !tx_ready; then DONE.
- RESET_N low during DUMP_TX at word 10 → tx_valid 0, state_o LOAD, cycle_cnt 0 immediately.
- With DBG_CYCLE_DUMP_EN → 65th word equals cycle_cnt.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared state encoding and constants for the MIPS debug sequencer.
`default_nettype none

package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_DUMP_RD = 3'd4,
    ST_DUMP_TX = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  localparam logic BANK_REG = 1'b0;
  localparam logic BANK_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dbg_edge_det.sv
// Registered rising-edge detector for the single-step input.
`default_nettype none

module dbg_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/mips_dbg_ctrl.sv
// Loader / run-control / state-dump sequencer for the pipelined MIPS core.
// Optional macro DBG_CYCLE_DUMP_EN appends cycle_cnt as a final dump word.
`default_nettype none

module mips_dbg_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int          PM_AW      = 8,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  parameter int          DUMP_WORDS = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             instr_valid,
  input  logic [31:0]      instr_data,
  output logic             instr_ready,
  input  logic             start,
  input  logic             run_mode,
  input  logic             step,
  input  logic             cpu_halted,
  output logic             pm_we,
  output logic [PM_AW-1:0] pm_addr,
  output logic [31:0]      pm_wdata,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             dbg_sel,
  output logic [4:0]       dbg_addr,
  input  logic [31:0]      dbg_rdata,
  output logic             tx_valid,
  output logic [31:0]      tx_data,
  input  logic             tx_ready,
  output logic [31:0]      cycle_cnt,
  output logic [2:0]       state_o
);

  localparam int DP_W = $clog2(2*DUMP_WORDS + 2);
`ifdef DBG_CYCLE_DUMP_EN
  localparam int N_DUMP = 2*DUMP_WORDS + 1;
`else
  localparam int N_DUMP = 2*DUMP_WORDS;
`endif
  localparam logic [DP_W-1:0]  DP_LAST = DP_W'(N_DUMP - 1);
  localparam logic [PM_AW-1:0] PM_LAST = '1;

  state_t            state, state_nxt;
  logic [PM_AW-1:0]  load_ptr;
  logic [DP_W-1:0]   dump_ptr;
  logic              step_rise;
  logic [31:0]       dump_word;

  dbg_edge_det u_step_det (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (step),
    .rise  (step_rise)
  );

  assign pm_addr  = load_ptr;
  assign pm_wdata = instr_data;
  assign dbg_sel  = dump_ptr[$clog2(DUMP_WORDS)] ? BANK_MEM : BANK_REG;
  assign dbg_addr = dump_ptr[4:0];
  assign state_o  = state;

`ifdef DBG_CYCLE_DUMP_EN
  assign dump_word = (dump_ptr == DP_LAST) ? cycle_cnt : dbg_rdata;
`else
  assign dump_word = dbg_rdata;
`endif

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    pm_we       = 1'b0;
    cpu_en      = 1'b0;
    cpu_rst     = 1'b0;
    tx_valid    = 1'b0;
    case (state)
      ST_LOAD: begin
        instr_ready = 1'b1;
        cpu_rst     = 1'b1;
        if (instr_valid) begin
          pm_we = 1'b1;
          if (instr_data == HALT_WORD || load_ptr == PM_LAST) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cpu_rst = 1'b1;
        if (start) state_nxt = run_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        cpu_en = 1'b1;
        if (cpu_halted) state_nxt = ST_DUMP_RD;
      end
      ST_STEP: begin
        // A step edge coinciding with halt still gets its pulse.
        cpu_en = step_rise;
        if (cpu_halted) state_nxt = ST_DUMP_RD;
      end
      ST_DUMP_RD: state_nxt = ST_DUMP_TX;
      ST_DUMP_TX: begin
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = (dump_ptr == DP_LAST) ? ST_DONE : ST_DUMP_RD;
      end
      ST_DONE: begin
        cpu_rst = 1'b1;
        if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_LOAD;
      load_ptr  <= '0;
      dump_ptr  <= '0;
      cycle_cnt <= '0;
      tx_data   <= '0;
    end else begin
      state <= state_nxt;
      // Pointer parks on the last address once memory is full.
      if (pm_we && load_ptr != PM_LAST) load_ptr <= load_ptr + PM_AW'(1);
      if (cpu_en && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == ST_DUMP_RD) tx_data <= dump_word;
      if (tx_valid && tx_ready) dump_ptr <= dump_ptr + DP_W'(1);
      if (state == ST_DONE && start) begin
        load_ptr  <= '0;
        dump_ptr  <= '0;
        cycle_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_dbg_ctrl.sv
// Directed bench for mips_dbg_ctrl: load, step, run, dump, abort, fill.
`default_nettype none

module tb_mips_dbg_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        start, run_mode, step, cpu_halted;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [31:0] pm_wdata;
  logic        cpu_en, cpu_rst, dbg_sel;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic [31:0] cycle_cnt;
  logic [2:0]  state_o;

`ifdef DBG_CYCLE_DUMP_EN
  localparam int NW = 65;
`else
  localparam int NW = 64;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mips_dbg_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .start(start), .run_mode(run_mode), .step(step), .cpu_halted(cpu_halted),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst),
    .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cycle_cnt(cycle_cnt), .state_o(state_o)
  );

  // Core debug port model: regfile reads 0xA000_00nn, data memory 0xD000_00nn.
  assign dbg_rdata = (dbg_sel ? 32'hD000_0000 : 32'hA000_0000) | {27'd0, dbg_addr};

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] tx_q[$];
  int          en_cnt = 0;

  always @(negedge CLK) begin
    if (pm_we) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_wdata);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (cpu_en) en_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc);
    int n = 0;
    while (state_o !== s && n < max_cyc) begin
      tick();
      n++;
    end
    chk("wait_state", {29'd0, state_o}, {29'd0, s});
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] v = i;
    if (i < 32) return 32'hA000_0000 | v;
    return 32'hD000_0000 | (v - 32'd32);
  endfunction

  logic [31:0] prog3 [3] = '{32'h2001_0005, 32'h2002_0007, 32'hFFFF_FFFF};

  initial begin
    int base, n;
    logic hold;
    logic [31:0] hold_data;

    RESET_N = 1'b0; instr_valid = 1'b0; instr_data = '0; start = 1'b0;
    run_mode = 1'b0; step = 1'b0; cpu_halted = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_pm_we", pm_we, 0);
    chk("rst_dbg", {dbg_sel, dbg_addr}, 0);
    RESET_N = 1'b1;
    tick();

    // Three-word program, continuous valid
    base = wr_addr_q.size();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; instr_data = prog3[i];
      #1;
      chk("ld_we", pm_we, 1);
      chk("ld_ready", instr_ready, 1);
      tick();
    end
    instr_valid = 1'b0;
    #1;
    chk("ld_state_wait", state_o, 1);
    chk("ld_ready_low", instr_ready, 0);
    chk("ld_count", wr_addr_q.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < wr_addr_q.size()) begin
        chk("ld_addr", wr_addr_q[base+i], i);
        chk("ld_data", wr_data_q[base+i], prog3[i]);
      end
    end

    // Step mode: held step gives one pulse, halt coincides with the 4th edge
    run_mode = 1'b1; start = 1'b1;
    #1;
    chk("wait_cpu_rst", cpu_rst, 1);
    tick();
    start = 1'b0;
    chk("step_state", state_o, 3);
    chk("step_cpu_rst", cpu_rst, 0);
    base = en_cnt;
    step = 1'b1;
    #1;
    chk("step_pulse", cpu_en, 1);
    repeat (10) tick();
    chk("step_held_one", en_cnt - base, 1);
    step = 1'b0; tick(); tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; cpu_halted = 1'b1;
    #1;
    chk("step_halt_pulse", cpu_en, 1);
    tick();
    step = 1'b0; cpu_halted = 1'b0;
    chk("step_to_dump", state_o, 4);
    chk("step_en_total", en_cnt - base, 4);
    chk("step_cycle", cycle_cnt, 4);
    base = tx_q.size();
    tx_ready = 1'b1;
    wait_state(3'd6, 400);
    chk("step_dump_cnt", tx_q.size() - base, NW);
    chk("done_cycle_held", cycle_cnt, 4);
    chk("done_cpu_rst", cpu_rst, 1);
    step = 1'b1;
    #1;
    chk("done_step_ignored", cpu_en, 0);
    step = 1'b0;
    tx_ready = 1'b0;

    // Restart, load with 5-cycle gaps between words
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_load", state_o, 0);
    chk("restart_cycle_clr", cycle_cnt, 0);
    base = wr_addr_q.size();
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      instr_data = (i == 3) ? 32'hFFFF_FFFF : 32'h0000_1000 + i;
      tick();
      instr_valid = 1'b0;
      if (i < 3) begin
        #1;
        chk("gap_no_we", pm_we, 0);
        repeat (5) tick();
      end
    end
    chk("gap_state_wait", state_o, 1);
    chk("gap_count", wr_addr_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < wr_addr_q.size()) chk("gap_addr", wr_addr_q[base+i], i);

    // Continuous run, halt on the 20th core cycle, throttled sink
    run_mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("run_state", state_o, 2);
    chk("run_cpu_en", cpu_en, 1);
    chk("run_cpu_rst", cpu_rst, 0);
    repeat (9) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("run_start_ignored", state_o, 2);
    repeat (9) tick();
    cpu_halted = 1'b1; tick(); cpu_halted = 1'b0;
    chk("run_to_dump", state_o, 4);
    chk("run_cycle", cycle_cnt, 20);
    chk("run_en_off", cpu_en, 0);
    base = tx_q.size();
    hold = 1'b0; hold_data = '0; n = 0;
    while (state_o !== 3'd6 && n < 600) begin
      if (hold) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, hold_data);
      end
      tx_ready = (n % 3 == 2);
      hold = tx_valid && !tx_ready;
      hold_data = tx_data;
      tick();
      n++;
    end
    tx_ready = 1'b0;
    chk("run_done", state_o, 6);
    chk("run_dump_cnt", tx_q.size() - base, NW);
    for (int i = 0; i < 64; i++)
      if (base + i < tx_q.size()) chk("dump_word", tx_q[base+i], exp_word(i));
`ifdef DBG_CYCLE_DUMP_EN
    if (base + 64 < tx_q.size()) chk("dump_cycle_word", tx_q[base+64], 20);
`endif

    // Abort by reset while word 10 is waiting in DUMP_TX
    start = 1'b1; tick(); start = 1'b0;
    instr_valid = 1'b1; instr_data = 32'hFFFF_FFFF; tick(); instr_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    cpu_halted = 1'b1; tick(); cpu_halted = 1'b0;
    chk("abort_cycle", cycle_cnt, 1);
    base = tx_q.size();
    tx_ready = 1'b1; n = 0;
    while (tx_q.size() - base < 10 && n < 100) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    wait_state(3'd5, 4);
    chk("abort_word10", dbg_addr, 10);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_state", state_o, 0);
    chk("abort_cycle_clr", cycle_cnt, 0);
    chk("abort_dbg_addr", dbg_addr, 0);
    #2 RESET_N = 1'b1;
    tick();

    // Fill all 256 locations without a halt word
    base = wr_addr_q.size();
    instr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      instr_data = 32'h1000_0000 + i;
      tick();
    end
    chk("fill_state", state_o, 1);
    #1;
    chk("fill_no_we", pm_we, 0);
    chk("fill_ready_low", instr_ready, 0);
    repeat (3) tick();
    instr_valid = 1'b0;
    chk("fill_count", wr_addr_q.size() - base, 256);
    if (wr_addr_q.size() > base) begin
      chk("fill_first", wr_addr_q[base], 0);
      chk("fill_last", wr_addr_q[wr_addr_q.size()-1], 255);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
